// File: rtl/udp_header_parser_stream.sv
// UDP header parser for a BEAT_BYTES-wide valid/ready byte stream: extracts the 8-byte header,
// matches dst_port against a programmable table, presents a header record, then forwards or drops payload.
module udp_header_parser_stream #(
    parameter int BEAT_BYTES     = 1,
    parameter int NUM_PORTS      = 4,
    parameter int DROP_UNMATCHED = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [8*BEAT_BYTES-1:0]                         s_data,
    input  logic                                            s_valid,
    input  logic                                            s_last,
    output logic                                            s_ready,
    input  logic [16*NUM_PORTS-1:0]                         port_table,
    input  logic [NUM_PORTS-1:0]                            port_en,
    output logic                                            hdr_valid,
    input  logic                                            hdr_ready,
    output logic [15:0]                                     src_port,
    output logic [15:0]                                     dst_port,
    output logic [15:0]                                     length,
    output logic [15:0]                                     checksum,
    output logic [NUM_PORTS-1:0]                            match_vec,
    output logic                                            port_match,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] match_idx,
    output logic                                            csum_present,
    output logic [8*BEAT_BYTES-1:0]                         m_data,
    output logic                                            m_valid,
    output logic                                            m_last,
    input  logic                                            m_ready,
    output logic                                            pkt_done,
    output logic                                            len_err,
    output logic                                            runt_err
);

    localparam int         IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int         SHIFT    = $clog2(BEAT_BYTES);
    localparam logic [3:0] LAST_CNT = 4'(8 - BEAT_BYTES);

    typedef enum logic [1:0] {HDR, HOLD, PAYLOAD, DROP} state_t;

    state_t               state, state_nxt;
    logic [3:0]           hdr_cnt;
    logic [63:0]          stage;
    logic [63:0]          hdr_nxt;
    logic                 hdr_last;
    logic [15:0]          beat_cnt;
    logic [15:0]          beat_inc;
    logic                 xfer;
    logic                 at_last;
    logic                 no_match_drop;
    logic [NUM_PORTS-1:0] mv_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 found;

    assign xfer          = s_valid && s_ready;
    assign at_last       = (hdr_cnt == LAST_CNT);
    assign m_data        = s_data;
    assign m_last        = s_last;
    assign beat_inc      = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
    assign no_match_drop = (DROP_UNMATCHED != 0) && (mv_nxt == '0);

    // Earlier header bytes shift up so byte 0 ends in the MSBs once the final beat lands.
    always_comb begin
        hdr_nxt = stage << (8 * BEAT_BYTES);
        hdr_nxt[8*BEAT_BYTES-1:0] = s_data;
    end

    always_comb begin
        mv_nxt  = '0;
        idx_nxt = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++)
            mv_nxt[i] = port_en[i] && (port_table[16*i +: 16] == hdr_nxt[47:32]);
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (mv_nxt[i] && !found) begin
                idx_nxt = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    function automatic logic len_bad(input logic [15:0] len, input logic [15:0] beats);
        logic [16:0] need;
        need = ({1'b0, len} - 17'd8 + 17'(BEAT_BYTES - 1)) >> SHIFT;
        return (len < 16'd8) || (need != {1'b0, beats});
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= HDR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR: begin
                if (xfer && at_last) begin
                    if (no_match_drop) state_nxt = s_last ? HDR : DROP;
                    else               state_nxt = HOLD;
                end
            end
            HOLD:          if (hdr_ready) state_nxt = hdr_last ? HDR : PAYLOAD;
            PAYLOAD, DROP: if (xfer && s_last) state_nxt = HDR;
            default:       state_nxt = HDR;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        hdr_valid = 1'b0;
        case (state)
            HDR:     s_ready = !rst;
            HOLD:    hdr_valid = 1'b1;
            PAYLOAD: begin
                s_ready = m_ready;
                m_valid = s_valid;
            end
            DROP:    s_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt      <= '0;
            stage        <= '0;
            hdr_last     <= 1'b0;
            beat_cnt     <= '0;
            src_port     <= '0;
            dst_port     <= '0;
            length       <= '0;
            checksum     <= '0;
            match_vec    <= '0;
            port_match   <= 1'b0;
            match_idx    <= '0;
            csum_present <= 1'b0;
            pkt_done     <= 1'b0;
            len_err      <= 1'b0;
            runt_err     <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            len_err  <= 1'b0;
            runt_err <= 1'b0;
            case (state)
                HDR: if (xfer) begin
                    stage <= hdr_nxt;
                    if (at_last) begin
                        hdr_cnt      <= '0;
                        src_port     <= hdr_nxt[63:48];
                        dst_port     <= hdr_nxt[47:32];
                        length       <= hdr_nxt[31:16];
                        checksum     <= hdr_nxt[15:0];
                        match_vec    <= mv_nxt;
                        port_match   <= |mv_nxt;
                        match_idx    <= idx_nxt;
                        csum_present <= (hdr_nxt[15:0] != '0);
                        hdr_last     <= s_last;
                        beat_cnt     <= '0;
                        if (no_match_drop && s_last) begin
                            pkt_done <= 1'b1;
                            len_err  <= len_bad(hdr_nxt[31:16], 16'd0);
                        end
                    end else if (s_last) begin
                        hdr_cnt  <= '0;
                        runt_err <= 1'b1;
                    end else begin
                        hdr_cnt <= hdr_cnt + 4'(BEAT_BYTES);
                    end
                end
                HOLD: if (hdr_ready && hdr_last) begin
                    pkt_done <= 1'b1;
                    len_err  <= len_bad(length, beat_cnt);
                end
                PAYLOAD, DROP: if (xfer) begin
                    beat_cnt <= beat_inc;
                    if (s_last) begin
                        pkt_done <= 1'b1;
                        len_err  <= len_bad(length, beat_inc);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_header_parser_stream.sv
// Bench for udp_header_parser_stream: a 1-byte dropping instance and a 4-byte forwarding instance,
// driven with directed and random packets and checked against a packet-level model.
module tb_udp_header_parser_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] port_table;
    logic [3:0]  port_en;

    logic [7:0]  a_sd, a_md;
    logic        a_sv, a_sl, a_mr, a_hr, a_sready, a_hv, a_pm, a_csp, a_mval, a_mlast, a_done, a_lerr, a_runt;
    logic [15:0] a_src, a_dst, a_len, a_cs;
    logic [3:0]  a_mv;
    logic [1:0]  a_idx;

    logic [31:0] b_sd, b_md;
    logic        b_sv, b_sl, b_mr, b_hr, b_sready, b_hv, b_pm, b_csp, b_mval, b_mlast, b_done, b_lerr, b_runt;
    logic [15:0] b_src, b_dst, b_len, b_cs;
    logic [3:0]  b_mv;
    logic [1:0]  b_idx;

    udp_header_parser_stream #(.BEAT_BYTES(1), .NUM_PORTS(4), .DROP_UNMATCHED(1)) dut_a (
        .clk(clk), .rst(rst), .s_data(a_sd), .s_valid(a_sv), .s_last(a_sl), .s_ready(a_sready),
        .port_table(port_table), .port_en(port_en), .hdr_valid(a_hv), .hdr_ready(a_hr),
        .src_port(a_src), .dst_port(a_dst), .length(a_len), .checksum(a_cs),
        .match_vec(a_mv), .port_match(a_pm), .match_idx(a_idx), .csum_present(a_csp),
        .m_data(a_md), .m_valid(a_mval), .m_last(a_mlast), .m_ready(a_mr),
        .pkt_done(a_done), .len_err(a_lerr), .runt_err(a_runt)
    );

    udp_header_parser_stream #(.BEAT_BYTES(4), .NUM_PORTS(4), .DROP_UNMATCHED(0)) dut_b (
        .clk(clk), .rst(rst), .s_data(b_sd), .s_valid(b_sv), .s_last(b_sl), .s_ready(b_sready),
        .port_table(port_table), .port_en(port_en), .hdr_valid(b_hv), .hdr_ready(b_hr),
        .src_port(b_src), .dst_port(b_dst), .length(b_len), .checksum(b_cs),
        .match_vec(b_mv), .port_match(b_pm), .match_idx(b_idx), .csum_present(b_csp),
        .m_data(b_md), .m_valid(b_mval), .m_last(b_mlast), .m_ready(b_mr),
        .pkt_done(b_done), .len_err(b_lerr), .runt_err(b_runt)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] d_data;
    logic        d_valid, d_last, d_mready, d_hready;

    logic        o_sready, o_hv, o_pm, o_csp, o_mval, o_mlast, o_done, o_lerr, o_runt;
    logic [15:0] o_src, o_dst, o_len, o_cs;
    logic [3:0]  o_mv;
    logic [1:0]  o_idx;
    logic [63:0] o_md;

    logic [15:0] e_src[2], e_dst[2], e_len[2], e_cs[2];
    logic [3:0]  e_mv[2];
    logic [1:0]  e_idx[2];

    logic [7:0]  pkt[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bb(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic bit dropu(input int d);
        return (d == 0);
    endfunction

    task automatic apply(input int d);
        a_sd = '0; a_sv = 1'b0; a_sl = 1'b0; a_mr = 1'b0; a_hr = 1'b0;
        b_sd = '0; b_sv = 1'b0; b_sl = 1'b0; b_mr = 1'b0; b_hr = 1'b0;
        if (d == 0) begin
            a_sd = d_data[7:0]; a_sv = d_valid; a_sl = d_last; a_mr = d_mready; a_hr = d_hready;
        end else begin
            b_sd = d_data[31:0]; b_sv = d_valid; b_sl = d_last; b_mr = d_mready; b_hr = d_hready;
        end
    endtask

    task automatic sample(input int d);
        if (d == 0) begin
            o_sready = a_sready; o_hv = a_hv; o_pm = a_pm; o_csp = a_csp; o_mval = a_mval;
            o_mlast = a_mlast; o_done = a_done; o_lerr = a_lerr; o_runt = a_runt;
            o_src = a_src; o_dst = a_dst; o_len = a_len; o_cs = a_cs; o_mv = a_mv; o_idx = a_idx;
            o_md = {56'b0, a_md};
        end else begin
            o_sready = b_sready; o_hv = b_hv; o_pm = b_pm; o_csp = b_csp; o_mval = b_mval;
            o_mlast = b_mlast; o_done = b_done; o_lerr = b_lerr; o_runt = b_runt;
            o_src = b_src; o_dst = b_dst; o_len = b_len; o_cs = b_cs; o_mv = b_mv; o_idx = b_idx;
            o_md = {32'b0, b_md};
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic half;
        @(negedge clk);
    endtask

    task automatic make_pkt(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                            input logic [15:0] cs, input int npay);
        pkt.delete();
        pkt.push_back(src[15:8]); pkt.push_back(src[7:0]);
        pkt.push_back(dst[15:8]); pkt.push_back(dst[7:0]);
        pkt.push_back(len[15:8]); pkt.push_back(len[7:0]);
        pkt.push_back(cs[15:8]);  pkt.push_back(cs[7:0]);
        for (int i = 0; i < npay; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic check_fields(input int d);
        chk("src_port", o_src, e_src[d]);
        chk("dst_port", o_dst, e_dst[d]);
        chk("length", o_len, e_len[d]);
        chk("checksum", o_cs, e_cs[d]);
        chk("match_vec", o_mv, e_mv[d]);
        chk("port_match", o_pm, |e_mv[d]);
        chk("match_idx", o_idx, e_idx[d]);
        chk("csum_present", o_csp, e_cs[d] != 16'h0);
    endtask

    // Sends pkt (padded to whole beats) to instance d and checks every cycle against packet-level expectations.
    task automatic run_pkt(input int d, input int hold, input int mrmode, input bit gaps);
        int B, beats, hb, npay, hv_cnt, cyc, bi, fwd, exp_fwd, l;
        bit runt, drop, le, hdr_done, finished, mr_t, pend_done, pend_runt, exp_done, exp_runt;
        bit ph_hdr, ph_hold, exp_sready, exp_mval, xfer;
        logic [63:0] w;
        logic [63:0] beat_w[$];
        logic [3:0]  mv;
        logic [1:0]  idx;

        B = bb(d);
        while (pkt.size() % B != 0) pkt.push_back(8'h00);
        beats = pkt.size() / B;
        hb = 8 / B;
        for (int b = 0; b < beats; b++) begin
            w = '0;
            for (int k = 0; k < B; k++) w = (w << 8) | 64'(pkt[b*B+k]);
            beat_w.push_back(w);
        end
        runt = beats < hb;
        drop = 1'b0; le = 1'b0; npay = 0;
        if (!runt) begin
            e_src[d] = {pkt[0], pkt[1]};
            e_dst[d] = {pkt[2], pkt[3]};
            e_len[d] = {pkt[4], pkt[5]};
            e_cs[d]  = {pkt[6], pkt[7]};
            mv = '0;
            idx = '0;
            for (int i = 0; i < 4; i++) mv[i] = port_en[i] && (port_table[16*i +: 16] == e_dst[d]);
            for (int i = 3; i >= 0; i--) if (mv[i]) idx = 2'(i);
            e_mv[d] = mv;
            e_idx[d] = idx;
            drop = dropu(d) && (mv == 4'b0);
            npay = beats - hb;
            l = int'(e_len[d]);
            le = (l < 8) || (npay != (l - 8 + B - 1) / B);
        end
        exp_fwd = (runt || drop) ? 0 : npay;

        bi = 0; fwd = 0; hv_cnt = 0; cyc = 0; hdr_done = 1'b0; finished = 1'b0;
        mr_t = 1'b1; pend_done = 1'b0; pend_runt = 1'b0;
        while (!finished && cyc < 600) begin
            exp_done = pend_done;
            exp_runt = pend_runt;
            pend_done = 1'b0;
            pend_runt = 1'b0;
            d_valid = (bi < beats) && (!gaps || $urandom_range(0, 3) != 0);
            d_data  = (bi < beats) ? beat_w[bi] : 64'h0;
            d_last  = d_valid && (bi == beats - 1);
            case (mrmode)
                0:       d_mready = 1'b1;
                1:       begin d_mready = mr_t; mr_t = !mr_t; end
                default: d_mready = 1'($urandom_range(0, 1));
            endcase
            d_hready = (hv_cnt >= hold);
            apply(d);
            half;
            sample(d);

            ph_hdr  = runt || (bi < hb);
            ph_hold = !ph_hdr && !drop && !hdr_done;
            if (ph_hdr)           exp_sready = 1'b1;
            else if (ph_hold)     exp_sready = 1'b0;
            else if (bi == beats) exp_sready = 1'b1;
            else if (drop)        exp_sready = 1'b1;
            else                  exp_sready = d_mready;
            exp_mval = !ph_hdr && !ph_hold && !drop && d_valid;

            chk("s_ready", o_sready, exp_sready);
            chk("hdr_valid", o_hv, ph_hold);
            chk("m_valid", o_mval, exp_mval);
            chk("pkt_done", o_done, exp_done);
            chk("len_err", o_lerr, exp_done && le);
            chk("runt_err", o_runt, exp_runt);
            if (ph_hold || exp_done || exp_runt) check_fields(d);
            if (exp_mval && d_mready) begin
                chk("m_data", o_md, beat_w[bi]);
                chk("m_last", o_mlast, d_last);
                fwd++;
            end
            if (o_hv) hv_cnt++;

            xfer = d_valid && o_sready;
            if (ph_hold && d_hready) begin
                hdr_done = 1'b1;
                if (beats == hb) pend_done = 1'b1;
            end
            if (xfer) begin
                if (bi == beats - 1) begin
                    if (runt)              pend_runt = 1'b1;
                    else if (beats > hb)   pend_done = 1'b1;
                    else if (drop)         pend_done = 1'b1;
                end
                bi++;
            end
            if (exp_done || exp_runt) finished = 1'b1;
            tick;
            cyc++;
        end
        chk("completed", finished, 1'b1);
        chk("fwd_beats", fwd, exp_fwd);
    endtask

    initial begin
        int d, B, npay, len, hold, mrm, nr, bi;
        bit gaps;
        logic [15:0] dst;

        rst = 1'b1;
        port_table = '0;
        port_en = '0;
        d_data = '0; d_valid = 1'b0; d_last = 1'b0; d_mready = 1'b0; d_hready = 1'b0;
        apply(0);
        for (int i = 0; i < 2; i++) begin
            e_src[i] = '0; e_dst[i] = '0; e_len[i] = '0; e_cs[i] = '0; e_mv[i] = '0; e_idx[i] = '0;
        end
        tick; tick;
        half;
        for (int i = 0; i < 2; i++) begin
            sample(i);
            chk("rst_flags", {o_sready, o_hv, o_mval, o_done, o_lerr, o_runt, o_pm, o_csp}, 8'h00);
            check_fields(i);
        end
        tick;
        rst = 1'b0;

        // Basic forward on the 1-byte instance
        port_table = 64'h0000_0000_0000_1F90;
        port_en = 4'b0001;
        make_pkt(16'h04D2, 16'h1F90, 16'h000C, 16'hABCD, 4);
        run_pkt(0, 0, 0, 1'b0);

        // Double match on the 4-byte instance with a held header record
        port_table = {16'h0035, 16'h0035, 16'h1234, 16'h1F90};
        port_en = 4'b1111;
        make_pkt(16'hC000, 16'h0035, 16'd16, 16'h0000, 8);
        run_pkt(1, 5, 0, 1'b0);

        // Unmatched packet consumed silently
        port_en = 4'b0000;
        make_pkt(16'h1234, 16'h0050, 16'd14, 16'h5555, 6);
        run_pkt(0, 0, 0, 1'b0);

        // Length errors and a header-only packet
        port_table = 64'h0000_0000_0000_1F90;
        port_en = 4'b0001;
        make_pkt(16'h0001, 16'h1F90, 16'h0010, 16'h0102, 5);
        run_pkt(0, 0, 0, 1'b0);
        make_pkt(16'h0002, 16'h1F90, 16'h0004, 16'h0304, 3);
        run_pkt(0, 1, 0, 1'b0);
        make_pkt(16'h0003, 16'h1F90, 16'h0008, 16'h0000, 0);
        run_pkt(0, 0, 0, 1'b0);

        // Runt followed by a clean packet
        pkt.delete();
        for (int i = 0; i < 6; i++) pkt.push_back(8'(8'hA0 + i));
        run_pkt(0, 0, 0, 1'b0);
        make_pkt(16'h0A0B, 16'h1F90, 16'd11, 16'h7777, 3);
        run_pkt(0, 0, 0, 1'b0);

        // Downstream backpressure toggling 1010...
        make_pkt(16'h5A5A, 16'h1F90, 16'd18, 16'h0F0F, 10);
        run_pkt(0, 1, 1, 1'b0);
        make_pkt(16'hA5A5, 16'h2222, 16'd21, 16'hF0F0, 13);
        run_pkt(1, 0, 1, 1'b1);

        // Reset in the middle of a forwarded payload
        make_pkt(16'h1111, 16'h1F90, 16'd20, 16'h0000, 12);
        bi = 0;
        for (int c = 0; c < 40 && bi < 10; c++) begin
            d_data = {56'b0, pkt[bi]}; d_valid = 1'b1; d_last = 1'b0; d_mready = 1'b1; d_hready = 1'b1;
            apply(0);
            half;
            sample(0);
            if (o_sready) bi++;
            tick;
        end
        chk("rst_setup_beats", bi, 10);
        rst = 1'b1;
        d_data = '0; d_valid = 1'b0; d_last = 1'b0; d_mready = 1'b0; d_hready = 1'b0;
        apply(0);
        tick;
        half;
        sample(0);
        for (int i = 0; i < 2; i++) begin
            e_src[i] = '0; e_dst[i] = '0; e_len[i] = '0; e_cs[i] = '0; e_mv[i] = '0; e_idx[i] = '0;
        end
        chk("rst_mid_flags", {o_sready, o_hv, o_mval, o_mlast, o_done, o_lerr, o_runt, o_pm, o_csp}, 9'h000);
        chk("rst_mid_mdata", o_md, 64'h0);
        check_fields(0);
        tick;
        rst = 1'b0;
        make_pkt(16'h2468, 16'h1F90, 16'd10, 16'h1357, 2);
        run_pkt(0, 0, 0, 1'b0);

        // Random packets across both instances
        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(0, 1));
            B = bb(d);
            for (int i = 0; i < 4; i++) port_table[16*i +: 16] = 16'($urandom_range(0, 7));
            port_en = 4'($urandom);
            dst = 16'($urandom_range(0, 7));
            hold = int'($urandom_range(0, 3));
            mrm = int'($urandom_range(0, 2));
            gaps = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                nr = int'($urandom_range(1, 8 - B));
                pkt.delete();
                for (int i = 0; i < nr; i++) pkt.push_back(8'($urandom));
            end else begin
                npay = int'($urandom_range(0, 12));
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : 8 + npay;
                make_pkt(16'($urandom), dst, 16'(len), 16'($urandom_range(0, 3)), npay);
            end
            run_pkt(d, hold, mrm, gaps);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udp_header_parser_stream.md
Name: udp_header_parser_stream

Overview:
- Parametrised successor to the byte-serial UDP header parser.
- Accepts a valid/ready byte stream of BEAT_BYTES bytes per beat and extracts the 8-byte UDP header.
- Matches the destination port against a programmable NUM_PORTS-entry table, presents the header as a handshaked record, and then forwards or drops the payload.
- Sits between the IP-layer deframer and the per-port payload consumers; also reports length and runt errors.

Parameters:
- BEAT_BYTES, 1, bytes per input beat; legal values 1, 2, 4, 8.
- NUM_PORTS, 4, number of port-table entries, 1..16.
- DROP_UNMATCHED, 1, 1 = unmatched packets raise no hdr_valid and their payload is consumed silently; 0 = every packet is presented and forwarded.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  8*BEAT_BYTES  input beat; byte 0 (first on wire) is in the MSBs.
- s_valid  in  1  input beat valid.
- s_last  in  1  final beat of packet.
- s_ready  out  1  input accept.
- port_table  in  16*NUM_PORTS  entry i is [16*i+:16].
- port_en  in  NUM_PORTS  per-entry enable.
- hdr_valid  out  1  header record valid.
- hdr_ready  in  1  header record accept.
- src_port, dst_port, length, checksum  out  16 each  latched header fields.
- match_vec  out  NUM_PORTS  per-entry match (entry enabled AND dst_port equal).
- port_match  out  1  OR of match_vec.
- match_idx  out  max(1,$clog2(NUM_PORTS))  lowest matching index; 0 if none.
- csum_present  out  1  checksum != 0.
- m_data  out  8*BEAT_BYTES  payload beat, equal to s_data.
- m_valid  out  1  payload beat valid.
- m_last  out  1  equal to s_last.
- m_ready  in  1  downstream accept.
- pkt_done  out  1  one-cycle pulse at end of packet.
- len_err  out  1  qualified by pkt_done.
- runt_err  out  1  one-cycle pulse when a packet ends inside its header.

Behaviour:
- Reset: all outputs 0; internal state HDR; byte and beat counters 0. A reset mid-packet abandons the packet; subsequent bytes are parsed as a fresh header (upstream must reset in step).
- Beat handshake: a beat transfers when s_valid && s_ready.
- HDR state:
  - s_ready=1; m_valid=0.
  - The header byte counter advances by BEAT_BYTES per beat.
  - Bytes 0-7 load src_port[15:8], src_port[7:0], dst_port[15:8], dst_port[7:0], length[15:8], length[7:0], checksum[15:8], checksum[7:0], as in the single-byte parser.
  - BEAT_BYTES=8 loads the entire header in one beat.
- Final header beat:
  - Fields, match_vec, port_match, match_idx and csum_present are registered the next edge.
  - port_table and port_en are sampled on that beat.
  - The beat's s_last is remembered as hdr_last.
- Routing after the final header beat:
  - If DROP_UNMATCHED=1 and there is no match: go to DROP if !hdr_last; otherwise pulse pkt_done and return to HDR.
  - Otherwise go to HOLD.
- s_last during HDR before byte 7: pulse runt_err, clear the header counter, stay in HDR, raise no hdr_valid or pkt_done, and leave the previously latched fields unchanged.
- HOLD state:
  - s_ready=0; hdr_valid=1.
  - On hdr_ready: go to PAYLOAD, or, if hdr_last, pulse pkt_done and go to HDR.
  - hdr_ready high in the first HOLD cycle completes in that cycle (one-cycle record latency).
  - Header outputs stay stable from entry into HOLD until the next final header beat.
- PAYLOAD state:
  - s_ready=m_ready; m_valid=s_valid; m_data/m_last pass through combinationally.
  - The beat counter increments per transferred beat, saturating at 16'hFFFF.
- DROP state: s_ready=1; m_valid=0; beats are counted the same way.
- PAYLOAD/DROP exit: s_last transfer pulses pkt_done the next cycle and returns to HDR.
- Length check, evaluated at pkt_done:
  - expected = (length<8) ? invalid : ceil((length-8)/BEAT_BYTES) beats.
  - len_err=1 if length<8 or observed payload beats != expected.
  - A zero-payload packet is valid when length==8.
- Back-to-back packets: HDR accepts the next header beat in the cycle after pkt_done returns the FSM to HDR. No bubble is needed when exiting from DROP.

Test Plan:
- BEAT_BYTES=1, table[0]=0x1F90 enabled; bytes 04 D2 1F 90 00 0C AB CD then 4 payload bytes, last on the 4th → hdr_valid with src=0x04D2, dst=0x1F90, length=12, checksum=0xABCD, match_vec=0001, idx=0, csum_present=1; 4 beats forwarded; pkt_done with len_err=0.
- BEAT_BYTES=4, dst=0x0035 matching table[2] and table[3] → match_vec=1100, match_idx=2; header complete after 2 beats; hold hdr_ready=0 for 5 cycles → s_ready=0 and fields stable throughout.
- DROP_UNMATCHED=1, dst=0x0050 with no entry enabled → no hdr_valid, m_valid stays 0; payload consumed at 1 beat/cycle; pkt_done pulses.
- length=0x0010 with only 5 payload bytes (BEAT_BYTES=1) → len_err=1; length=0x0004 → len_err=1; length=0x0008 with s_last on byte 7 → pkt_done, len_err=0, no PAYLOAD state.
- s_last on header byte 5 → runt_err pulse, no hdr_valid; the next packet parses correctly.
- PAYLOAD with m_ready toggling 1010… → no beat lost or duplicated; assert rst mid-payload → all outputs 0 the next cycle and FSM in HDR.
